// File: rtl/dsm_integrator_chain_pkg.sv
// Shared definitions for the DSM integrator chain.
// Holds the lane FSM state encoding, LFSR seed/taps for optional dither,
// symmetric saturation limits and the clamp helper used by every stage.
// No ports (package).
package dsm_pkg;

   // Widest accumulator the clamp helper supports (sums carry one extra bit).
   localparam int unsigned MaxAccW = 63;

   typedef logic [0:0] dsm_state_t;
   localparam dsm_state_t StRun     = 1'b0;
   localparam dsm_state_t StRecover = 1'b1;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
   localparam logic [15:0] LfsrSeed = 16'hACE1;
   localparam logic [15:0] LfsrTaps = 16'hB400;

   // Limits for the default 40-bit accumulator.
   localparam int unsigned DefAccW = 40;
   localparam logic signed [DefAccW-1:0] DefAccMax = {1'b0, {(DefAccW-1){1'b1}}};
   localparam logic signed [DefAccW-1:0] DefAccMin = -DefAccMax;

   // +(2^(acc_w-1) - 1), the symmetric magnitude limit for an acc_w-bit accumulator.
   function automatic logic signed [MaxAccW:0] acc_max(input int unsigned acc_w);
      acc_max = ({{MaxAccW{1'b0}}, 1'b1} << (acc_w - 1)) - 1'b1;
   endfunction

   // Clamp to +/-acc_max(acc_w); the most-negative code is never produced.
   function automatic logic signed [MaxAccW:0] sat_clamp(input logic signed [MaxAccW:0] sum,
                                                         input int unsigned acc_w);
      logic signed [MaxAccW:0] lim;
      lim = acc_max(acc_w);
      if (sum > lim) begin
         sat_clamp = lim;
      end else if (sum < -lim) begin
         sat_clamp = -lim;
      end else begin
         sat_clamp = sum;
      end
   endfunction

endpackage

// File: rtl/dsm_integrator_chain_if.sv
// Bus bundle for dsm_integrator_chain.
// CE_I/DATA_I: sample strobe and packed per-channel signed input.
// DATA_O/VALID_O/SAT_O/RECOVER_O: last-stage accumulators, step pulse, flags.
// master = source/sink outside the chain, slave = the chain itself.
interface dsm_integrator_chain_if #(
   parameter int unsigned CH    = 2,
   parameter int unsigned IN_W  = 33,
   parameter int unsigned ACC_W = 40
);
   logic                  CE_I;
   logic [CH*IN_W-1:0]    DATA_I;
   logic [CH*ACC_W-1:0]   DATA_O;
   logic                  VALID_O;
   logic [CH-1:0]         SAT_O;
   logic [CH-1:0]         RECOVER_O;

   modport master (
      output CE_I, DATA_I,
      input  DATA_O, VALID_O, SAT_O, RECOVER_O
   );

   modport slave (
      input  CE_I, DATA_I,
      output DATA_O, VALID_O, SAT_O, RECOVER_O
   );
endinterface

// File: rtl/dsm_integrator_chain_lane.sv
// One channel of the integrator chain: ORDER cascaded saturating integrators
// (delayed form), saturation run counter and RUN/RECOVER FSM.
// Ports: clk, rst (sync, active-high), ce (step strobe), x (signed input),
//        dither_up (only with DSM_DITHER_EN: 1 -> +1, 0 -> -1 into stage 1),
//        data (last-stage accumulator), sat (clamped on latest step),
//        recover (FSM in RECOVER).
module dsm_integrator_lane
   import dsm_pkg::*;
#(
   parameter int unsigned IN_W          = 33,
   parameter int unsigned ACC_W         = 40,
   parameter int unsigned ORDER         = 3,
   parameter int unsigned SAT_LIMIT     = 4,
   parameter int unsigned RECOVER_TICKS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic signed [IN_W-1:0]  x,
`ifdef DSM_DITHER_EN
   input  logic                    dither_up,
`endif
   output logic signed [ACC_W-1:0] data,
   output logic                    sat,
   output logic                    recover
);

   logic signed [ACC_W-1:0]   acc_q [ORDER];
   logic signed [ACC_W-1:0]   step  [ORDER];
   logic signed [ACC_W:0]     sum   [ORDER];
   logic signed [MaxAccW:0]   lim   [ORDER];
   logic [ORDER-1:0]          clamped;
   logic [7:0]                satcnt_q;
   logic [7:0]                recnt_q;
   dsm_state_t                state_q;
   logic                      sat_q;

   // Every stage reads the pre-update value of its predecessor.
   always_comb begin
      sum[0] = {acc_q[0][ACC_W-1], acc_q[0]} + {{(ACC_W+1-IN_W){x[IN_W-1]}}, x};
`ifdef DSM_DITHER_EN
      sum[0] = sum[0] + {{ACC_W{~dither_up}}, 1'b1};
`endif
      for (int k = 1; k < ORDER; k++) begin
         sum[k] = {acc_q[k][ACC_W-1], acc_q[k]} + {acc_q[k-1][ACC_W-1], acc_q[k-1]};
      end
      clamped = '0;
      for (int k = 0; k < ORDER; k++) begin
         lim[k]     = sat_clamp((MaxAccW+1)'(sum[k]), ACC_W);
         step[k]    = ACC_W'(lim[k]);
         clamped[k] = lim[k] != (MaxAccW+1)'(sum[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
         satcnt_q <= '0;
         recnt_q  <= '0;
         state_q  <= StRun;
         sat_q    <= 1'b0;
      end else if (ce) begin
         if (state_q == StRun) begin
            sat_q <= |clamped;
            if (|clamped) begin
               satcnt_q <= satcnt_q + 8'd1;
               if (satcnt_q + 8'd1 == 8'(SAT_LIMIT)) begin
                  // Runaway: discard this step and start recovery from zero.
                  for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
                  state_q <= StRecover;
                  recnt_q <= '0;
               end else begin
                  acc_q <= step;
               end
            end else begin
               satcnt_q <= '0;
               acc_q    <= step;
            end
         end else begin
            for (int k = 0; k < ORDER; k++) acc_q[k] <= '0;
            sat_q   <= 1'b0;
            recnt_q <= recnt_q + 8'd1;
            if (recnt_q + 8'd1 == 8'(RECOVER_TICKS)) begin
               state_q  <= StRun;
               satcnt_q <= '0;
            end
         end
      end
   end

   assign data    = acc_q[ORDER-1];
   assign sat     = sat_q;
   assign recover = (state_q == StRecover);

endmodule

// File: rtl/dsm_integrator_chain.sv
// CH-channel cascade of ORDER saturating DSM integrators with per-channel
// instability recovery. Sits between the delta stage and the quantiser.
// Ports: BCLK_I (clock, posedge), RESET_I (sync, active-high),
//        bus (slave modport): CE_I, DATA_I in; DATA_O, VALID_O, SAT_O, RECOVER_O out.
// Optional build macro DSM_DITHER_EN: shared 16-bit LFSR adds +/-1 per channel
// to the first stage, advancing on every CE_I.
module dsm_integrator_chain
   import dsm_pkg::*;
#(
   parameter int unsigned CH            = 2,
   parameter int unsigned IN_W          = 33,
   parameter int unsigned ACC_W         = 40,
   parameter int unsigned ORDER         = 3,
   parameter int unsigned SAT_LIMIT     = 4,
   parameter int unsigned RECOVER_TICKS = 8
) (
   input logic                   BCLK_I,
   input logic                   RESET_I,
   dsm_integrator_chain_if.slave bus
);

   logic valid_q;

`ifdef DSM_DITHER_EN
   logic [15:0] lfsr_q;

   // Advances on every strobe, including while lanes recover.
   always_ff @(posedge BCLK_I) begin
      if (RESET_I) begin
         lfsr_q <= LfsrSeed;
      end else if (bus.CE_I) begin
         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
      end
   end
`endif

   always_ff @(posedge BCLK_I) begin
      if (RESET_I) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.CE_I;
      end
   end

   assign bus.VALID_O = valid_q;

   for (genvar c = 0; c < CH; c++) begin : g_lane
      dsm_integrator_lane #(
         .IN_W          (IN_W),
         .ACC_W         (ACC_W),
         .ORDER         (ORDER),
         .SAT_LIMIT     (SAT_LIMIT),
         .RECOVER_TICKS (RECOVER_TICKS)
      ) u_lane (
         .clk       (BCLK_I),
         .rst       (RESET_I),
         .ce        (bus.CE_I),
         .x         (bus.DATA_I[c*IN_W +: IN_W]),
`ifdef DSM_DITHER_EN
         .dither_up (lfsr_q[c]),
`endif
         .data      (bus.DATA_O[c*ACC_W +: ACC_W]),
         .sat       (bus.SAT_O[c]),
         .recover   (bus.RECOVER_O[c])
      );
   end

endmodule

// File: tb/tb_dsm_integrator_chain.sv
// Bench for dsm_integrator_chain: an ORDER=1 and an ORDER=2 instance share stimulus.
// A reference model pushes expected outputs per strobe; they are popped on the
// following cycle and all outputs are checked every cycle (so holding is checked too).
module tb_dsm_integrator_chain;

   localparam int unsigned CH            = 2;
   localparam int unsigned IN_W          = 33;
   localparam int unsigned ACC_W         = 40;
   localparam int unsigned SAT_LIMIT     = 4;
   localparam int unsigned RECOVER_TICKS = 8;
   localparam longint AccMax = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
   localparam longint XMax   = (64'sd1 <<< (IN_W - 1)) - 64'sd1;

   typedef struct packed {
      logic signed [63:0] d0;
      logic signed [63:0] d1;
      logic [1:0]         sat;
      logic [1:0]         rec;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dsm_integrator_chain_if #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC_W)) if1 ();
   dsm_integrator_chain_if #(.CH(CH), .IN_W(IN_W), .ACC_W(ACC_W)) if2 ();

   dsm_integrator_chain #(
      .CH(CH), .IN_W(IN_W), .ACC_W(ACC_W), .ORDER(1),
      .SAT_LIMIT(SAT_LIMIT), .RECOVER_TICKS(RECOVER_TICKS)
   ) dut1 (
      .BCLK_I  (clk),
      .RESET_I (rst),
      .bus     (if1)
   );

   dsm_integrator_chain #(
      .CH(CH), .IN_W(IN_W), .ACC_W(ACC_W), .ORDER(2),
      .SAT_LIMIT(SAT_LIMIT), .RECOVER_TICKS(RECOVER_TICKS)
   ) dut2 (
      .BCLK_I  (clk),
      .RESET_I (rst),
      .bus     (if2)
   );

   int vectors;
   int errors;
   bit exp_valid;
   exp_t q1[$];
   exp_t q2[$];
   exp_t cur1;
   exp_t cur2;
   logic signed [63:0] obs1c0[$];
   logic signed [63:0] obs1c1[$];
   logic signed [63:0] obs2c0[$];

   // Reference state: [dut][channel][stage]; dut 0 is ORDER=1, dut 1 is ORDER=2.
   longint acc [2][2][2];
   int     satcnt [2][2];
   int     recnt [2][2];
   bit     st [2][2];
   bit     satf [2][2];
   logic [15:0] lfsr_m;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint clampf(input longint v, output bit hit);
      hit = (v > AccMax) || (v < -AccMax);
      if (v > AccMax) return AccMax;
      if (v < -AccMax) return -AccMax;
      return v;
   endfunction

   function automatic longint dith(input int c);
`ifdef DSM_DITHER_EN
      return lfsr_m[c] ? 64'sd1 : -64'sd1;
`else
      return (c < 0) ? 64'sd1 : 64'sd0;
`endif
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            acc[d][c][0] = 0;
            acc[d][c][1] = 0;
            satcnt[d][c] = 0;
            recnt[d][c]  = 0;
            st[d][c]     = 1'b0;
            satf[d][c]   = 1'b0;
         end
      end
      lfsr_m = 16'hACE1;
      q1.delete();
      q2.delete();
      cur1 = '0;
      cur2 = '0;
   endtask

   task automatic model_step(input longint x0, input longint x1);
      longint xs [2];
      longint nw [2];
      bit hit;
      bit any;
      exp_t e;
      xs[0] = x0;
      xs[1] = x1;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            if (!st[d][c]) begin
               nw[0] = clampf(acc[d][c][0] + xs[c] + dith(c), hit);
               any = hit;
               nw[1] = 0;
               if (d == 1) begin
                  nw[1] = clampf(acc[d][c][1] + acc[d][c][0], hit);
                  any = any | hit;
               end
               satf[d][c] = any;
               if (any) begin
                  satcnt[d][c]++;
                  if (satcnt[d][c] == SAT_LIMIT) begin
                     nw[0] = 0;
                     nw[1] = 0;
                     st[d][c] = 1'b1;
                     recnt[d][c] = 0;
                  end
               end else begin
                  satcnt[d][c] = 0;
               end
               acc[d][c][0] = nw[0];
               acc[d][c][1] = nw[1];
            end else begin
               acc[d][c][0] = 0;
               acc[d][c][1] = 0;
               satf[d][c] = 1'b0;
               recnt[d][c]++;
               if (recnt[d][c] == RECOVER_TICKS) begin
                  st[d][c] = 1'b0;
                  satcnt[d][c] = 0;
               end
            end
         end
         e.d0  = acc[d][0][d];
         e.d1  = acc[d][1][d];
         e.sat = {satf[d][1], satf[d][0]};
         e.rec = {st[d][1], st[d][0]};
         if (d == 0) q1.push_back(e);
         else q2.push_back(e);
      end
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   endtask

   task automatic check_outputs();
      if (exp_valid) begin
         chk("sb1_depth", q1.size(), 1);
         chk("sb2_depth", q2.size(), 1);
         if (q1.size() > 0) cur1 = q1.pop_front();
         if (q2.size() > 0) cur2 = q2.pop_front();
         obs1c0.push_back($signed(if1.DATA_O[ACC_W-1:0]));
         obs1c1.push_back($signed(if1.DATA_O[2*ACC_W-1:ACC_W]));
         obs2c0.push_back($signed(if2.DATA_O[ACC_W-1:0]));
      end
      chk("o1_valid", if1.VALID_O, exp_valid);
      chk("o1_data_ch0", $signed(if1.DATA_O[ACC_W-1:0]), cur1.d0);
      chk("o1_data_ch1", $signed(if1.DATA_O[2*ACC_W-1:ACC_W]), cur1.d1);
      chk("o1_sat", if1.SAT_O, cur1.sat);
      chk("o1_recover", if1.RECOVER_O, cur1.rec);
      chk("o2_valid", if2.VALID_O, exp_valid);
      chk("o2_data_ch0", $signed(if2.DATA_O[ACC_W-1:0]), cur2.d0);
      chk("o2_data_ch1", $signed(if2.DATA_O[2*ACC_W-1:ACC_W]), cur2.d1);
      chk("o2_sat", if2.SAT_O, cur2.sat);
      chk("o2_recover", if2.RECOVER_O, cur2.rec);
   endtask

   task automatic cycle(input bit r, input bit ce, input longint x0, input longint x1);
      rst = r;
      if1.CE_I = ce;
      if2.CE_I = ce;
      if1.DATA_I = {IN_W'(x1), IN_W'(x0)};
      if2.DATA_I = {IN_W'(x1), IN_W'(x0)};
      if (r) model_reset();
      else if (ce) model_step(x0, x1);
      @(posedge clk);
      #1;
      exp_valid = ce && !r;
      check_outputs();
   endtask

   task automatic clear_obs();
      obs1c0.delete();
      obs1c1.delete();
      obs2c0.delete();
   endtask

   initial begin
      longint seq2 [5];
      vectors   = 0;
      errors    = 0;
      exp_valid = 1'b0;
      if1.CE_I = 1'b0;
      if2.CE_I = 1'b0;
      if1.DATA_I = '0;
      if2.DATA_I = '0;
      model_reset();

      // Reset, including reset winning over a simultaneous strobe.
      cycle(1, 0, 0, 0);
      cycle(1, 1, 7, 7);
      cycle(0, 0, 0, 0);

      // Constant input, strobe every cycle.
      clear_obs();
      for (int i = 0; i < 6; i++) cycle(0, 1, 5, -3);
      cycle(0, 0, 5, -3);
      for (int i = 0; i < 6; i++) begin
         chk("o1_ramp_ch0", (i < obs1c0.size()) ? obs1c0[i] : 'x, 5 * (i + 1));
         chk("o1_ramp_ch1", (i < obs1c1.size()) ? obs1c1[i] : 'x, -3 * (i + 1));
      end

      // Strobe every 4th cycle, x=1: ORDER=2 gives triangular numbers.
      cycle(1, 0, 0, 0);
      clear_obs();
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 1, 0);
         for (int j = 0; j < 3; j++) cycle(0, 0, 1, 0);
      end
      seq2 = '{0, 1, 3, 6, 10};
      for (int i = 0; i < 5; i++) begin
         chk("o2_tri_ch0", (i < obs2c0.size()) ? obs2c0[i] : 'x, seq2[i]);
         chk("o1_cnt_ch0", (i < obs1c0.size()) ? obs1c0[i] : 'x, i + 1);
      end

      // Drive toward clamp; 3 sat / 1 clear / 3 sat / 1 clear must not recover.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 128; i++) cycle(0, 1, XMax, 1);
      chk("o1_near_max", $signed(if1.DATA_O[ACC_W-1:0]), AccMax - 127);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 3; i++) cycle(0, 1, XMax, 1);
         chk("o1_stuck_max", $signed(if1.DATA_O[ACC_W-1:0]), AccMax);
         chk("o1_sat_flag", if1.SAT_O[0], 1);
         cycle(0, 1, -1, 1);
         chk("o1_unsat", $signed(if1.DATA_O[ACC_W-1:0]), AccMax - 1);
         chk("o1_no_recover", if1.RECOVER_O[0], 0);
      end
      // Four in a row triggers recovery on ch0 only.
      for (int i = 0; i < 4; i++) cycle(0, 1, XMax, 1);
      chk("o1_recover_on", if1.RECOVER_O[0], 1);
      chk("o1_cleared", $signed(if1.DATA_O[ACC_W-1:0]), 0);
      chk("o1_ch1_indep", if1.RECOVER_O[1], 0);

      // Reset with a strobe while recovering.
      for (int i = 0; i < 3; i++) cycle(0, 1, XMax, 1);
      cycle(1, 1, XMax, 1);
      chk("o1_rst_recover", if1.RECOVER_O[0], 0);
      cycle(0, 1, 5, -3);
      chk("o1_after_rst", $signed(if1.DATA_O[ACC_W-1:0]), 5);

      // Full recovery and resume from zero.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 132; i++) cycle(0, 1, XMax, 0);
      chk("o1_full_rec_on", if1.RECOVER_O[0], 1);
      for (int i = 0; i < 7; i++) cycle(0, 1, XMax, 0);
      chk("o1_still_rec", if1.RECOVER_O[0], 1);
      chk("o1_rec_zero", $signed(if1.DATA_O[ACC_W-1:0]), 0);
      cycle(0, 1, XMax, 0);
      chk("o1_rec_done", if1.RECOVER_O[0], 0);
      chk("o1_rec_done_zero", $signed(if1.DATA_O[ACC_W-1:0]), 0);
      cycle(0, 1, XMax, 0);
      chk("o1_resume", $signed(if1.DATA_O[ACC_W-1:0]), XMax);

      // Zero input: with dither a +/-1 walk, otherwise constant zero.
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
